table_fsm: RTL
==============

Name: table_fsm

Overview:
- Programmable, table-driven FSM stepped by a two-bit input symbol {a,b}.
- Next-state table is loaded at run time through a config write port, so one block covers any sequence/gesture recogniser up to NSTATES states.
- Illegal steps are detected in hardware (error pulse plus saturating counter), not only reported in simulation; output mode (Moore or Mealy) is selected by parameter.
- Sits between input-capture logic and display/decode logic.

Parameters:
SW, 4, state/output width in bits
NSTATES, 6, number of legal states (2..2**SW); state indices 0..NSTATES-1
MEALY, 0, 0 = out is current state (Moore); 1 = out is the look-ahead next state (Mealy)
ERRW, 8, width of the error counter

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  step strobe; a/b sampled only when en=1
a  input  1  symbol bit 1 (MSB of sym)
b  input  1  symbol bit 0 (LSB of sym)
cfg_we  input  1  table write strobe
cfg_state  input  SW  table row (source state)
cfg_sym  input  2  table column (symbol {a,b})
cfg_next  input  SW  destination state to store
cfg_valid  input  1  1 = legal transition, 0 = illegal
out  output  SW  state code (see MEALY)
err  output  1  one-cycle pulse on an illegal step
err_cnt  output  ERRW  saturating count of illegal steps
step_cnt  output  16  wrapping count of accepted (legal) steps

Behaviour:
- Table: NSTATES x 4 entries; each entry is {valid, next[SW-1:0]}; sym = {a,b}.
- Reset (rst=1, asynchronous):
  - state=0, err=0, err_cnt=0, step_cnt=0.
  - All table entries cleared to valid=0, next=0.
  - out=0 in both modes.
- Table write: on a rising edge with cfg_we=1 and cfg_state<NSTATES, entry[cfg_state][cfg_sym] <= {cfg_valid, cfg_next}.
  - cfg_state>=NSTATES: write ignored.
  - cfg_next>=NSTATES is stored as-is; it is caught when used (see below).
- Step: on a rising edge with en=1, look up e = entry[state][sym].
  - e.valid=1 and e.next<NSTATES: state <= e.next; step_cnt++ (wraps at 2**16); err <= 0.
  - e.valid=0: state is held; err <= 1 for exactly one cycle; err_cnt++ saturating at 2**ERRW-1.
  - e.valid=1 but e.next>=NSTATES: state <= 0; err <= 1; err_cnt++ (saturating).
- Idle: en=0 -> state, step_cnt and err_cnt hold; err <= 0.
- Same-edge write and step: the step uses the old entry contents; the new value is visible from the next cycle.
- Latency, Moore (MEALY=0):
  - out = state, registered; updates 1 cycle after the en edge.
- Latency, Mealy (MEALY=1):
  - out is combinational: en=1 and the lookup is legal -> out = e.next (0 cycles); otherwise out = state.
  - Out-of-range next gives out=0.
- Reset mid-operation: an asynchronous assert immediately forces all of the reset values above.
  - The table is lost and must be reprogrammed.
  - err is never asserted on the cycle after reset deassertion.
- State register corruption: if state>=NSTATES (unreachable by design), the next en step forces state=0 and pulses err.

Test Plan:
- Reset then en=1 with sym=2'b11 and an empty table -> err pulses one cycle, err_cnt=1, out=0, step_cnt=0.
- Program 0-(11)->1, 1-(10)->4, 4-(01)->5, 5-(10)->1 (all valid); step 11,10,01,10 -> Moore out sequence 1,4,5,1 (each one cycle after its en), step_cnt=4, err never high.
- Same table, MEALY=1, state=1, drive en=1 sym=10 -> out=4 in the same cycle before the edge; en=0 -> out=1.
- Write entry[1][00]={1,9} with NSTATES=6 while state=1, then step sym=00 -> state=0, err pulse, err_cnt+1.
- Same-edge cfg_we (entry[0][11]={1,3}) and en with sym=11 from state 0 and old entry {1,1} -> state=1; the next visit to state 0 with sym=11 goes to 3.
- ERRW=2: issue 5 illegal steps -> err_cnt reads 1,2,3,3,3; assert rst mid-sequence asynchronously (between edges) -> out, err_cnt, step_cnt=0 immediately, table cleared.

Source files
------------

// File: rtl/table_fsm.sv
// -----------------------------------------------------------------------------
// table_fsm
//
// Programmable, table-driven state machine stepped by a two-bit symbol {a,b}.
// The next-state table (NSTATES rows x 4 symbol columns) is written at run time
// through the cfg_* port, so the same block can implement any sequence or
// gesture recogniser with up to NSTATES states.
//
// Each table entry holds {valid, next}. A step (en=1) looks up the entry for
// the current state and symbol:
//   - valid and next in range : move to next, count the step
//   - not valid               : hold the state, pulse err, count the error
//   - valid but next too large: force state 0, pulse err, count the error
// A corrupted state register (state >= NSTATES) is also recovered to 0 with
// an error on the next step.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous reset, active-high (clears state, counters, table)
//   en         step strobe; a/b are sampled only when en=1
//   a, b       symbol bits, sym = {a,b}
//   cfg_we     table write strobe
//   cfg_state  table row to write (source state); rows >= NSTATES are ignored
//   cfg_sym    table column to write (symbol)
//   cfg_next   destination state to store (stored as-is, checked when used)
//   cfg_valid  1 = legal transition, 0 = illegal
//   out        Moore (MEALY=0): registered current state
//              Mealy (MEALY=1): combinational look-ahead of the next state
//   err        one-cycle pulse after an illegal step
//   err_cnt    saturating count of illegal steps
//   step_cnt   wrapping count of legal steps
// -----------------------------------------------------------------------------
module table_fsm #(
    parameter int SW      = 4,
    parameter int NSTATES = 6,
    parameter int MEALY   = 0,
    parameter int ERRW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            a,
    input  logic            b,
    input  logic            cfg_we,
    input  logic [SW-1:0]   cfg_state,
    input  logic [1:0]      cfg_sym,
    input  logic [SW-1:0]   cfg_next,
    input  logic            cfg_valid,
    output logic [SW-1:0]   out,
    output logic            err,
    output logic [ERRW-1:0] err_cnt,
    output logic [15:0]     step_cnt
);

    // Row index width: just wide enough to address NSTATES rows.
    localparam int IDXW = (NSTATES > 1) ? $clog2(NSTATES) : 1;
    // NSTATES as an SW+1 bit value so NSTATES == 2**SW still compares correctly.
    localparam logic [SW:0] NST_W = (SW + 1)'(NSTATES);

    // Outcome of the current cycle's step request.
    typedef enum logic [1:0] {
        STEP_IDLE   = 2'd0,   // no step requested
        STEP_GO     = 2'd1,   // legal transition
        STEP_HOLD   = 2'd2,   // illegal entry, state held
        STEP_FORCE0 = 2'd3    // bad destination or corrupted state, go to 0
    } step_e;

    // Saturating increment for the error counter.
    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        logic [ERRW-1:0] r;
        if (v == {ERRW{1'b1}}) begin
            r = v;
        end else begin
            r = v + ERRW'(1);
        end
        return r;
    endfunction

    // Transition table storage.
    logic            tbl_valid_q [NSTATES][4];
    logic [SW-1:0]   tbl_next_q  [NSTATES][4];

    // Machine state and counters.
    logic [SW-1:0]   state_q,    state_d;
    logic            err_q,      err_d;
    logic [ERRW-1:0] err_cnt_q,  err_cnt_d;
    logic [15:0]     step_cnt_q, step_cnt_d;

    // Lookup path.
    logic [1:0]      sym_s;
    logic            state_ok_s;
    logic [IDXW-1:0] row_s;
    logic            e_valid_s;
    logic [SW-1:0]   e_next_s;
    logic            e_next_ok_s;
    step_e           step_s;

    // Config write decode.
    logic            cfg_row_ok_s;
    logic [IDXW-1:0] cfg_row_s;

    assign sym_s        = {a, b};
    assign state_ok_s   = ({1'b0, state_q} < NST_W);
    // A corrupted state would index past the table; read row 0 instead, the
    // entry is ignored in that case anyway.
    assign row_s        = state_ok_s ? state_q[IDXW-1:0] : {IDXW{1'b0}};
    assign e_valid_s    = tbl_valid_q[row_s][sym_s];
    assign e_next_s     = tbl_next_q[row_s][sym_s];
    assign e_next_ok_s  = ({1'b0, e_next_s} < NST_W);

    assign cfg_row_ok_s = ({1'b0, cfg_state} < NST_W);
    assign cfg_row_s    = cfg_state[IDXW-1:0];

    // Table write port; a step on the same edge still sees the old entry
    // because the lookup reads the registered contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NSTATES; r++) begin
                for (int c = 0; c < 4; c++) begin
                    tbl_valid_q[r][c] <= 1'b0;
                    tbl_next_q[r][c]  <= {SW{1'b0}};
                end
            end
        end else if (cfg_we && cfg_row_ok_s) begin
            tbl_valid_q[cfg_row_s][cfg_sym] <= cfg_valid;
            tbl_next_q[cfg_row_s][cfg_sym]  <= cfg_next;
        end else begin
            // table holds
        end
    end

    // Classify the step request for this cycle.
    always_comb begin
        step_s = STEP_IDLE;
        if (!en) begin
            step_s = STEP_IDLE;
        end else if (!state_ok_s) begin
            step_s = STEP_FORCE0;
        end else if (!e_valid_s) begin
            step_s = STEP_HOLD;
        end else if (!e_next_ok_s) begin
            step_s = STEP_FORCE0;
        end else begin
            step_s = STEP_GO;
        end
    end

    // Next-state and counter update for each step outcome.
    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        step_cnt_d = step_cnt_q;
        case (step_s)
            STEP_IDLE: begin
                state_d = state_q;
            end
            STEP_GO: begin
                state_d    = e_next_s;
                step_cnt_d = step_cnt_q + 16'd1;
            end
            STEP_HOLD: begin
                state_d   = state_q;
                err_d     = 1'b1;
                err_cnt_d = sat_inc(err_cnt_q);
            end
            STEP_FORCE0: begin
                state_d   = {SW{1'b0}};
                err_d     = 1'b1;
                err_cnt_d = sat_inc(err_cnt_q);
            end
            default: begin
                state_d = {SW{1'b0}};
            end
        endcase
    end

    // State, error flag and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= {SW{1'b0}};
            err_q      <= 1'b0;
            err_cnt_q  <= {ERRW{1'b0}};
            step_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // In Mealy mode the output is the state the register is about to take:
    // the legal destination, 0 for a bad destination, or the held state.
    // While rst is high the table is empty and state is 0, so this is 0 too.
    generate
        if (MEALY != 0) begin : g_mealy
            assign out = state_d;
        end else begin : g_moore
            assign out = state_q;
        end
    endgenerate

    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign step_cnt = step_cnt_q;

endmodule
